rr_stream_mux: RTL and testbench

- Parametrised N-to-1 data multiplexer with a valid/ready handshake on every input and on the output, and round-robin arbitration between inputs.
- One output register stage.
- Next generation of the 2:1 8-bit combinational selector: many channels, any width, flow control, and fair arbitration in place of a static select.
- Sits between multiple producers (e.g. per-source datapaths) and a single shared consumer.

---
 rtl/rr_mux_pkg.sv | 39 +++
 rtl/rr_stream_mux_if.sv | 34 +++
 rtl/rr_arbiter.sv | 38 +++
 rtl/rr_stream_mux.sv | 108 ++++++++++
 tb/tb_rr_stream_mux.sv | 136 +++++++++++++
 5 files changed

// File: rtl/rr_mux_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux_pkg
// Shared helpers for round-robin stream multiplexers and arbiters.
//   chan_w   : width of a channel index for n channels (never below 1).
//   rr_first : first set request bit at or after a pointer, wrapping modulo n.
//              Returns {found, index[3:0]}; supports up to MAX_CH requesters.
// -----------------------------------------------------------------------------
package rr_mux_pkg;

    localparam int MAX_CH = 16;

    function automatic int chan_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // The search runs from the far end back towards ptr so that the last
    // hit written, i.e. the one nearest ptr, wins. ptr and k are both below n,
    // so a single conditional subtract implements the wrap.
    function automatic logic [4:0] rr_first(input logic [MAX_CH-1:0] req,
                                            input int n,
                                            input int ptr);
        logic [4:0] result;
        int         idx;
        result = '0;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx]) begin
                    result = {1'b1, 4'(idx)};
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// -----------------------------------------------------------------------------
// rr_stream_mux_if
// Handshake bundle of the round-robin stream mux.
//   in_data/in_valid/in_ready     : NUM_CH producer channels (packed words,
//                                   channel i at [i*DATA_W +: DATA_W]).
//   out_data/out_chan/out_valid/out_ready : single consumer stream.
// Modports:
//   master : producer/consumer side that drives inputs and out_ready.
//   slave  : the multiplexer itself.
// -----------------------------------------------------------------------------
interface rr_stream_mux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    localparam int CHAN_W = rr_mux_pkg::chan_w(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [CHAN_W-1:0]        out_chan;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter: grants the first requesting
// channel at or after ptr, wrapping modulo NUM_CH.
// Ports:
//   req       in  NUM_CH  request per channel
//   ptr       in  CHAN_W  search start position
//   grant     out NUM_CH  one-hot grant (all zero when nobody requests)
//   grant_idx out CHAN_W  encoded grant index (0 when no grant)
//   grant_vld out 1       some channel is granted
// -----------------------------------------------------------------------------
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CHAN_W = chan_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CHAN_W-1:0] ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CHAN_W-1:0] grant_idx,
    output logic              grant_vld
);
    logic [MAX_CH-1:0] req_pad;
    logic [4:0]        first;

    assign req_pad   = MAX_CH'(req);
    assign first     = rr_first(req_pad, NUM_CH, int'(ptr));
    assign grant_vld = first[4];
    assign grant_idx = first[CHAN_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_grant
            assign grant[gi] = grant_vld && (first[3:0] == 4'(gi));
        end
    endgenerate
endmodule

// File: rtl/rr_stream_mux.sv
// -----------------------------------------------------------------------------
// rr_stream_mux
// NUM_CH-to-1 valid/ready stream multiplexer with round-robin arbitration and
// a single registered output stage (full throughput, 1-cycle latency).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (clears output register and pointer,
//          forces in_ready low)
//   bus  : rr_stream_mux_if.slave (inputs, in_ready, registered outputs)
// Optional build macro RR_MUX_FORCE_SEL_EN adds:
//   force_en  : bypass arbitration, only force_sel may be granted
//   force_sel : forced channel (values >= NUM_CH grant nothing)
//   Forced transfers leave the round-robin pointer untouched.
// -----------------------------------------------------------------------------
module rr_stream_mux
    import rr_mux_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  DATA_W = 8,
    localparam int CHAN_W = chan_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef RR_MUX_FORCE_SEL_EN
    input  logic              force_en,
    input  logic [CHAN_W-1:0] force_sel,
`endif
    rr_stream_mux_if.slave    bus
);
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [CHAN_W-1:0] grant_idx;
    logic              grant_vld;
    logic              load;
    logic              accept;
    logic              ptr_advance;

    logic [CHAN_W-1:0] ptr_reg;
    logic [CHAN_W-1:0] ptr_next;
    logic [DATA_W-1:0] out_data_reg;
    logic [CHAN_W-1:0] out_chan_reg;
    logic              out_valid_reg;

    logic [DATA_W-1:0] word [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_word
            assign word[gi] = bus.in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef RR_MUX_FORCE_SEL_EN
    // Forcing masks every request except force_sel; an out-of-range select
    // matches no bit and therefore yields no grant.
    logic [NUM_CH-1:0] force_mask;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_force
            assign force_mask[gi] = (32'(force_sel) == gi);
        end
    endgenerate
    assign req         = force_en ? (bus.in_valid & force_mask) : bus.in_valid;
    assign ptr_advance = ~force_en;
`else
    assign req         = bus.in_valid;
    assign ptr_advance = 1'b1;
`endif

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CHAN_W (CHAN_W)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // The register can take a word when empty or when it drains this cycle.
    assign load         = ~out_valid_reg | bus.out_ready;
    assign accept       = grant_vld & load & ~rst;
    assign bus.in_ready = grant & {NUM_CH{load & ~rst}};

    assign ptr_next = (grant_idx == CHAN_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            ptr_reg       <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= word[grant_idx];
            out_chan_reg  <= grant_idx;
            if (ptr_advance) begin
                ptr_reg <= ptr_next;
            end
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_chan  = out_chan_reg;
    assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_rr_stream_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_stream_mux
// Directed, table-driven bench for rr_stream_mux (NUM_CH=4, DATA_W=8).
// Each row: inputs applied after the falling edge, in_ready checked before the
// rising edge, registered outputs checked just after it.
// Hand-written tails cover saturation fairness and (when RR_MUX_FORCE_SEL_EN
// is defined) forced selection.
// -----------------------------------------------------------------------------
module tb_rr_stream_mux;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam logic [31:0] STD = 32'h1312_1110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef RR_MUX_FORCE_SEL_EN
    logic       force_en  = 1'b0;
    logic [1:0] force_sel = 2'd0;
`endif

    rr_stream_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    rr_stream_mux #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef RR_MUX_FORCE_SEL_EN
        .force_en  (force_en),
        .force_sel (force_sel),
`endif
        .bus       (bus.slave)
    );

    typedef struct {
        logic        r;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [1:0]  exp_oc;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        rst          = v.r;
        bus.in_valid = v.valid;
        bus.in_data  = v.data;
        bus.out_ready = v.rdy;
        #1;
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'(v.exp_ov));
        check({tag, " out_data"}, 32'(bus.out_data), 32'(v.exp_od));
        check({tag, " out_chan"}, 32'(bus.out_chan), 32'(v.exp_oc));
        $display("%s: rst=%b valid=%b rdy=%b -> in_ready=%b out_valid=%b out_data=%h out_chan=%0d",
                 tag, v.r, v.valid, v.rdy, bus.in_ready, bus.out_valid, bus.out_data, bus.out_chan);
    endtask

    initial begin
        int   sat_ptr;
        vec_t v;

        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        //           rst   valid    data          rdy   in_ready ov    od     oc
        vecs[0]  = '{1'b1, 4'b1111, STD,          1'b1, 4'b0000, 1'b0, 8'h00, 2'd0}; // reset
        vecs[1]  = '{1'b0, 4'b0000, STD,          1'b1, 4'b0000, 1'b0, 8'h00, 2'd0}; // idle
        vecs[2]  = '{1'b0, 4'b1000, 32'h3C121110, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3}; // single ch3
        vecs[3]  = '{1'b0, 4'b0011, STD,          1'b1, 4'b0001, 1'b1, 8'h10, 2'd0}; // wrap to 0
        vecs[4]  = '{1'b0, 4'b1001, STD,          1'b1, 4'b1000, 1'b1, 8'h13, 2'd3}; // sparse, ptr=1
        vecs[5]  = '{1'b0, 4'b1001, STD,          1'b1, 4'b0001, 1'b1, 8'h10, 2'd0}; // then ch0
        vecs[6]  = '{1'b0, 4'b1111, STD,          1'b1, 4'b0010, 1'b1, 8'h11, 2'd1}; // ch1
        vecs[7]  = '{1'b0, 4'b1111, STD,          1'b0, 4'b0000, 1'b1, 8'h11, 2'd1}; // backpressure
        vecs[8]  = '{1'b0, 4'b1111, STD,          1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
        vecs[9]  = '{1'b0, 4'b1111, STD,          1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
        vecs[10] = '{1'b0, 4'b1111, STD,          1'b1, 4'b0100, 1'b1, 8'h12, 2'd2}; // drain+fill
        vecs[11] = '{1'b0, 4'b0000, STD,          1'b1, 4'b0000, 1'b0, 8'h12, 2'd2}; // drain only
        vecs[12] = '{1'b0, 4'b0000, STD,          1'b0, 4'b0000, 1'b0, 8'h12, 2'd2}; // idle, empty
        vecs[13] = '{1'b0, 4'b0100, STD,          1'b0, 4'b0100, 1'b1, 8'h12, 2'd2}; // fill when empty
        vecs[14] = '{1'b0, 4'b1111, STD,          1'b0, 4'b0000, 1'b1, 8'h12, 2'd2}; // full, stalled
        vecs[15] = '{1'b1, 4'b0100, 32'h13A51110, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0}; // reset mid-stream
        vecs[16] = '{1'b0, 4'b1111, STD,          1'b1, 4'b0001, 1'b1, 8'h10, 2'd0}; // search from 0

        for (int i = 0; i < NVEC; i++) begin
            step($sformatf("row%0d", i), vecs[i]);
        end

        // Saturation: all valid, consumer always ready -> chan 1,2,3,0,1,...
        sat_ptr = 1;
        for (int k = 0; k < 8; k++) begin
            v = '{1'b0, 4'b1111, STD, 1'b1, 4'(1 << sat_ptr), 1'b1,
                  8'(8'h10 + sat_ptr), 2'(sat_ptr)};
            step($sformatf("sat%0d", k), v);
            sat_ptr = (sat_ptr + 1) % NUM_CH;
        end

`ifdef RR_MUX_FORCE_SEL_EN
        // Forced channel 2 repeatedly; pointer must stay where it was (1).
        force_en  = 1'b1;
        force_sel = 2'd2;
        for (int k = 0; k < 3; k++) begin
            v = '{1'b0, 4'b1111, STD, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
            step($sformatf("force%0d", k), v);
        end
        force_en = 1'b0;
        v = '{1'b0, 4'b1111, STD, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        step("force_resume", v);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
